// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : UART transmitter with TX FIFO, run-time baud divisor and
//           configurable frame format; frames are sent back to back.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_DEFAULT = 434
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_en,
    input  logic [7:0]                   data,
    input  logic                         div_we,
    input  logic [15:0]                  div_in,
    input  logic                         clr_overflow,
    output logic                         tx,
    output logic                         uart_busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   c_DIV_RESET  = 16'(DIV_DEFAULT);
    localparam logic [3:0]    c_LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    c_LAST_STOP  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full, r_empty, r_ovf, r_busy, r_tx, r_par;
    logic [15:0]          r_shadow, r_div, r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    state_t               r_state;

    state_t               w_state_next;
    logic                 w_tx_next, w_pop, w_load, w_push, w_drop, w_bit_end;
    logic [15:0]          w_baud_next;
    logic [3:0]           w_bit_next;
    logic [DATA_BITS-1:0] w_shift_next, w_head;
    logic [CW-1:0]        w_count_next;
    logic                 w_unused_data;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_bit_end     = (r_baud == r_div - 16'd1);
    assign w_push        = write_en && (!r_full || w_pop);
    assign w_drop        = write_en && r_full && !w_pop;
    assign w_unused_data = ^data;

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_baud_next  = r_baud + 16'd1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_baud_next = 16'd0;
                w_bit_next  = 4'd0;
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = 16'd0;
                    w_bit_next   = 4'd0;
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = 16'd0;
                    if (r_bit == c_LAST_DATA) begin
                        w_bit_next = 4'd0;
                        if (PARITY != 0) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_next   = r_bit + 4'd1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_next  = 16'd0;
                    w_bit_next   = 4'd0;
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = 16'd0;
                    if (r_bit == c_LAST_STOP) begin
                        w_bit_next = 4'd0;
                        // Chain straight into the next start bit when data is queued
                        if (!r_empty) begin
                            w_pop        = 1'b1;
                            w_load       = 1'b1;
                            w_shift_next = w_head;
                            w_state_next = S_START;
                            w_tx_next    = 1'b0;
                        end else begin
                            w_state_next = S_IDLE;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_baud   <= 16'd0;
            r_bit    <= 4'd0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_div    <= c_DIV_RESET;
            r_shadow <= c_DIV_RESET;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            if (w_load) begin
                r_par <= (PARITY == 2) ? ~^w_head : ^w_head;
                r_div <= r_shadow;
            end
            if (div_we)
                r_shadow <= (div_in == 16'd0) ? 16'd1 : div_in;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
            r_empty <= (w_count_next == '0);
            r_busy  <= (w_state_next != S_IDLE) || (w_count_next != '0);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_overflow)
                r_ovf <= 1'b0;
        end
    end

    assign tx         = r_tx;
    assign uart_busy  = r_busy;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Directed self-checking bench for uart_tx_fifo (four configurations)
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic [15:0] div_in;
    logic        clr_overflow;
    logic [3:0]  we, dwe;

    logic tx0, tx1, tx2, tx3, busy0, busy1, busy2, busy3;
    logic full0, full1, full2, full3, empty0, empty1, empty2, empty3;
    logic ovf0, ovf1, ovf2, ovf3;
    logic [4:0] cnt0, cnt2, cnt3;
    logic [2:0] cnt1;
    logic [3:0] txv, busyv, fullv, emptyv, ovfv;

    int tests = 0;
    int fails = 0;
    int w;
    logic seen_low;

    always #5 clk = ~clk;

    assign txv    = {tx3, tx2, tx1, tx0};
    assign busyv  = {busy3, busy2, busy1, busy0};
    assign fullv  = {full3, full2, full1, full0};
    assign emptyv = {empty3, empty2, empty1, empty0};
    assign ovfv   = {ovf3, ovf2, ovf1, ovf0};

    uart_tx_fifo #(.FIFO_DEPTH(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .write_en(we[0]), .data(data), .div_we(dwe[0]),
        .div_in(div_in), .clr_overflow(clr_overflow), .tx(tx0), .uart_busy(busy0),
        .fifo_full(full0), .fifo_empty(empty0), .fifo_count(cnt0), .overflow(ovf0));

    uart_tx_fifo #(.FIFO_DEPTH(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .write_en(we[1]), .data(data), .div_we(dwe[1]),
        .div_in(div_in), .clr_overflow(clr_overflow), .tx(tx1), .uart_busy(busy1),
        .fifo_full(full1), .fifo_empty(empty1), .fifo_count(cnt1), .overflow(ovf1));

    uart_tx_fifo #(.FIFO_DEPTH(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .write_en(we[2]), .data(data), .div_we(dwe[2]),
        .div_in(div_in), .clr_overflow(clr_overflow), .tx(tx2), .uart_busy(busy2),
        .fifo_full(full2), .fifo_empty(empty2), .fifo_count(cnt2), .overflow(ovf2));

    uart_tx_fifo #(.FIFO_DEPTH(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .write_en(we[3]), .data(data), .div_we(dwe[3]),
        .div_in(div_in), .clr_overflow(clr_overflow), .tx(tx3), .uart_busy(busy3),
        .fifo_full(full3), .fifo_empty(empty3), .fifo_count(cnt3), .overflow(ovf3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // exp[0] is the start bit; the current negedge is frame cycle 'first' once tx is low
    task automatic check_frame(input int idx, input int nbits, input logic [11:0] exp,
                               input int div, input int first, input string tag,
                               output int waited);
        waited = 0;
        while (txv[idx] !== 1'b0 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("%s_start", tag), 32'(txv[idx]), 32'd0);
        if (txv[idx] === 1'b0) begin
            for (int k = first; k < nbits * div; k++) begin
                if (k != first) @(negedge clk);
                chk($sformatf("%s_bit%0d", tag, k / div), 32'(txv[idx]), 32'(exp[k / div]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; data = 8'h00; div_in = 16'd0; clr_overflow = 1'b0;
        we = 4'b0000; dwe = 4'b0000;
        step(3);
        rst = 1'b0;

        // 1: idle after reset
        step(100);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_tx%0d", i),    32'(txv[i]),    32'd1);
            chk($sformatf("t1_busy%0d", i),  32'(busyv[i]),  32'd0);
            chk($sformatf("t1_empty%0d", i), 32'(emptyv[i]), 32'd1);
            chk($sformatf("t1_full%0d", i),  32'(fullv[i]),  32'd0);
            chk($sformatf("t1_ovf%0d", i),   32'(ovfv[i]),   32'd0);
        end
        chk("t1_cnt0", 32'(cnt0), 32'd0);
        chk("t1_cnt1", 32'(cnt1), 32'd0);

        // 2: single 0xA5 frame at 4 clk/bit, with latency
        dwe = 4'b0001; div_in = 16'd4; step(1); dwe = 4'b0000;
        data = 8'hA5; we = 4'b0001; step(1); we = 4'b0000;
        chk("t2_e0_empty", 32'(empty0), 32'd0);
        chk("t2_e0_busy",  32'(busy0),  32'd1);
        chk("t2_e0_tx",    32'(tx0),    32'd1);
        chk("t2_e0_cnt",   32'(cnt0),   32'd1);
        step(1);
        chk("t2_e1_tx",    32'(tx0),    32'd0);
        chk("t2_e1_empty", 32'(empty0), 32'd1);
        check_frame(0, 10, 12'b00_1_10100101_0, 4, 0, "t2_a5", w);
        chk("t2_wait", 32'(w), 32'd0);
        step(1);
        chk("t2_busy_end", 32'(busy0), 32'd0);
        chk("t2_tx_end",   32'(tx0),   32'd1);

        // 3: three back-to-back frames
        data = 8'h55; we = 4'b0001; step(1);
        data = 8'h0F; step(1);
        data = 8'hF0; step(1); we = 4'b0000;
        chk("t3_cnt_peak", 32'(cnt0), 32'd2);
        check_frame(0, 10, 12'b00_1_01010101_0, 4, 1, "t3_55", w);
        check_frame(0, 10, 12'b00_1_00001111_0, 4, 0, "t3_0f", w);
        chk("t3_gap_0f", 32'(w), 32'd1);
        check_frame(0, 10, 12'b00_1_11110000_0, 4, 0, "t3_f0", w);
        chk("t3_gap_f0", 32'(w), 32'd1);
        step(1);
        chk("t3_busy_end", 32'(busy0), 32'd0);

        // 7: divisor change mid-frame applies from the next frame
        data = 8'h3C; we = 4'b0001; step(1);
        data = 8'hC3; step(1); we = 4'b0000;
        dwe = 4'b0001; div_in = 16'd8;
        fork
            begin @(negedge clk); dwe = 4'b0000; end
        join_none
        check_frame(0, 10, 12'b00_1_00111100_0, 4, 0, "t7_div4", w);
        check_frame(0, 10, 12'b00_1_11000011_0, 8, 0, "t7_div8", w);
        chk("t7_gap", 32'(w), 32'd1);
        step(1);
        chk("t7_busy_end", 32'(busy0), 32'd0);

        // 4: depth-4 FIFO overflow at divisor 100
        dwe = 4'b0010; div_in = 16'd100; step(1); dwe = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            data = 8'h11 + 8'(i); we = 4'b0010; step(1);
        end
        we = 4'b0000;
        chk("t4_cnt",  32'(cnt1),  32'd4);
        chk("t4_full", 32'(full1), 32'd1);
        chk("t4_ovf",  32'(ovf1),  32'd1);
        step(10);
        chk("t4_ovf_sticky", 32'(ovf1), 32'd1);
        clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
        chk("t4_ovf_clr", 32'(ovf1), 32'd0);
        check_frame(1, 10, 12'b00_1_00010001_0, 100, 15, "t4_11", w);
        check_frame(1, 10, 12'b00_1_00010010_0, 100, 0, "t4_12", w);
        chk("t4_gap12", 32'(w), 32'd1);
        check_frame(1, 10, 12'b00_1_00010011_0, 100, 0, "t4_13", w);
        check_frame(1, 10, 12'b00_1_00010100_0, 100, 0, "t4_14", w);
        check_frame(1, 10, 12'b00_1_00010101_0, 100, 0, "t4_15", w);
        chk("t4_gap15", 32'(w), 32'd1);
        step(1);
        chk("t4_busy_end",  32'(busy1),  32'd0);
        chk("t4_empty_end", 32'(empty1), 32'd1);
        seen_low = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx1 !== 1'b1) seen_low = 1'b1;
        end
        chk("t4_no_sixth", 32'(seen_low), 32'd0);

        // 5: parity and two stop bits; also div_in=0 stored as 1
        dwe = 4'b1100; div_in = 16'd4; step(1); dwe = 4'b0000;
        data = 8'h07; we = 4'b0100; step(1); we = 4'b0000; step(1);
        check_frame(2, 12, 12'b1_1_1_00000111_0, 4, 0, "t5_even", w);
        step(1);
        chk("t5_even_busy", 32'(busy2), 32'd0);
        data = 8'h07; we = 4'b1000; step(1); we = 4'b0000; step(1);
        check_frame(3, 11, 12'b0_1_0_00000111_0, 4, 0, "t5_odd", w);
        dwe = 4'b1000; div_in = 16'd0; step(1); dwe = 4'b0000;
        data = 8'h00; we = 4'b1000; step(1); we = 4'b0000; step(1);
        check_frame(3, 11, 12'b0_1_1_00000000_0, 1, 0, "t5_div0", w);

        // 6: reset in the middle of the data bits
        dwe = 4'b0001; div_in = 16'd4; step(1); dwe = 4'b0000;
        data = 8'h00; we = 4'b0001; step(1);
        data = 8'h81; step(1); we = 4'b0000;
        step(6);
        chk("t6_pre_tx",  32'(tx0),  32'd0);
        chk("t6_pre_cnt", 32'(cnt0), 32'd1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("t6_tx",    32'(tx0),    32'd1);
        chk("t6_empty", 32'(empty0), 32'd1);
        chk("t6_cnt",   32'(cnt0),   32'd0);
        chk("t6_busy",  32'(busy0),  32'd0);
        seen_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx0 !== 1'b1) seen_low = 1'b1;
        end
        chk("t6_no_restart", 32'(seen_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
